// File: rtl/gfx256_rd_arbiter.sv
// gfx256_rd_arbiter: round-robin share of the 256-bit master read port
// between z (0), texture (1) and blend (2); GFX256_RDARB_CACHE_EN adds a line cache.
module gfx256_rd_arbiter (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [2:0]   req_i,
   input  logic [31:0]  addr0_i,
   input  logic [31:0]  addr1_i,
   input  logic [31:0]  addr2_i,
   input  logic [31:0]  sel0_i,
   input  logic [31:0]  sel1_i,
   input  logic [31:0]  sel2_i,
   output logic [2:0]   ack_o,
   output logic [255:0] data_o,
   output logic [2:0]   busy_o,
   output logic         m_request_o,
   output logic [31:0]  m_addr_o,
   output logic [31:0]  m_sel_o,
   input  logic         m_ack_i,
   input  logic [255:0] m_data_i,
   input  logic         m_busy_i,
   input  logic         inval_i
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      RELEASE
   } state_t;

   state_t       state;
   logic [1:0]   ptr;
   logic [1:0]   gnt;
   logic [2:0]   mask;

   logic [2:0]   cand;
   logic [1:0]   pick;
   logic         pick_vld;
   logic [31:0]  pick_addr;
   logic [31:0]  pick_sel;

   logic         hit;
   logic [255:0] hit_line;

   function automatic logic [2:0] onehot3(input logic [1:0] idx);
      logic [2:0] r;
      r = 3'b000;
      case (idx)
         2'd1:    r = 3'b010;
         2'd2:    r = 3'b100;
         default: r = 3'b001;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] next_ptr(input logic [1:0] idx);
      logic [1:0] r;
      case (idx)
         2'd0:    r = 2'd1;
         2'd1:    r = 2'd2;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   assign cand     = req_i & ~mask;
   assign pick_vld = |cand;

   // first candidate at or after ptr, searching upward modulo 3
   always_comb begin
      pick = 2'd0;
      case (ptr)
         2'd1:    pick = cand[1] ? 2'd1 : (cand[2] ? 2'd2 : 2'd0);
         2'd2:    pick = cand[2] ? 2'd2 : (cand[0] ? 2'd0 : 2'd1);
         default: pick = cand[0] ? 2'd0 : (cand[1] ? 2'd1 : 2'd2);
      endcase
   end

   // address and byte selects of the selected requester
   always_comb begin
      pick_addr = addr0_i;
      pick_sel  = sel0_i;
      case (pick)
         2'd1: begin
            pick_addr = addr1_i;
            pick_sel  = sel1_i;
         end
         2'd2: begin
            pick_addr = addr2_i;
            pick_sel  = sel2_i;
         end
         default: begin
            pick_addr = addr0_i;
            pick_sel  = sel0_i;
         end
      endcase
   end

`ifdef GFX256_RDARB_CACHE_EN
   logic         c_valid;
   logic [26:0]  c_tag;
   logic [255:0] c_line;
   logic         inval_seen;

   // an invalidate in the same cycle as a lookup wins over the hit
   assign hit      = c_valid & ~inval_i & (c_tag == pick_addr[31:5]);
   assign hit_line = c_line;

   // line fill on completed miss; invalidate seen mid-read suppresses the fill
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         c_valid    <= 1'b0;
         c_tag      <= '0;
         c_line     <= '0;
         inval_seen <= 1'b0;
      end else begin
         if (state == IDLE) begin
            inval_seen <= 1'b0;
         end else if (inval_i &&
                      (state == ISSUE || state == WAIT_ACK)) begin
            inval_seen <= 1'b1;
         end
         if (inval_i) begin
            c_valid <= 1'b0;
         end else if (state == WAIT_ACK && m_ack_i && !inval_seen) begin
            c_valid <= 1'b1;
            c_tag   <= m_addr_o[31:5];
            c_line  <= m_data_i;
         end
      end
   end
`else
   logic unused_inval;

   assign unused_inval = inval_i;
   assign hit          = 1'b0;
   assign hit_line     = '0;
`endif

   assign busy_o = (state != IDLE || m_busy_i) ? 3'b111 : mask;

   // arbitration and master handshake state machine
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         ptr         <= 2'd0;
         mask        <= 3'b000;
         gnt         <= 2'd0;
         ack_o       <= 3'b000;
         data_o      <= '0;
         m_request_o <= 1'b0;
         m_addr_o    <= 32'h0000_0000;
         m_sel_o     <= 32'hFFFF_FFFF;
      end else begin
         ack_o <= 3'b000;
         case (state)
            IDLE: begin
               mask <= 3'b000;
               if (pick_vld && (hit || !m_busy_i)) begin
                  gnt <= pick;
                  if (hit) begin
                     ack_o  <= onehot3(pick);
                     data_o <= hit_line;
                     state  <= RELEASE;
                  end else begin
                     m_addr_o <= pick_addr;
                     m_sel_o  <= pick_sel;
                     state    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               m_request_o <= 1'b1;
               state       <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (m_ack_i) begin
                  data_o      <= m_data_i;
                  m_request_o <= 1'b0;
                  ack_o       <= onehot3(gnt);
                  state       <= RELEASE;
               end
            end
            RELEASE: begin
               ptr   <= next_ptr(gnt);
               mask  <= onehot3(gnt);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
